// File: rtl/ysyx_22050019_pipe_reg.sv
// ysyx_22050019_pipe_reg: pipeline-stage register with a valid/ready handshake,
// a synchronous flush and an optional 2-entry skid buffer.
//   clk        : clock, every state update happens on posedge
//   rst_n      : synchronous reset, active-HIGH despite the legacy name
//   flush      : drop every held beat at the next edge
//   in_valid / in_ready / in_data    : upstream side
//   out_valid / out_ready / out_data : downstream side (out_data = oldest beat)
//   count      : beats held (0..2 with SKID=1, 0..1 with SKID=0)
module ysyx_22050019_pipe_reg #(
  parameter int unsigned   DW        = 32,
  parameter logic [DW-1:0] RESET_VAL = '0,
  parameter int unsigned   SKID      = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  // State encoding doubles as the beat count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          fire_in, fire_out;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

  // Skid variant takes ready from a flop (no out_ready->in_ready path); the
  // single-entry variant needs the combinational pass-through for full rate.
  // Both are masked while reset is held.
  assign in_ready = ((SKID != 0) ? in_ready_q : (~out_valid | out_ready)) & ~rst_n;

  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  // Next-state and data-load logic; flush overrides the handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fire_in) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (fire_in) begin
            // Without a skid entry, accepting in ONE implies a same-cycle drain.
            if (fire_out || (SKID == 0)) begin
              main_d = in_data;
            end else begin
              skid_d  = in_data;
              state_d = ST_FULL;
            end
          end else if (fire_out) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (fire_out) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // State registers; reset leaves in_ready_q high so the stage accepts in
  // the first cycle after release (the output is masked during reset).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_pipe_reg.sv
// Bench for ysyx_22050019_pipe_reg: one SKID=1 and one SKID=0 instance on a
// shared clock/reset/flush, directed vectors plus a random scoreboard run.
module tb_ysyx_22050019_pipe_reg;

  localparam int unsigned     DW    = 32;
  localparam logic [DW-1:0]   RV1   = 32'h5A5A_0000;
  localparam logic [DW-1:0]   RV0   = 32'h0000_A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;

  logic          iv1 = 1'b0, ir1, ov1, or1 = 1'b0;
  logic [DW-1:0] id1 = '0, od1;
  logic [1:0]    cnt1;
  logic          iv0 = 1'b0, ir0, ov0, or0 = 1'b0;
  logic [DW-1:0] id0 = '0, od0;
  logic [1:0]    cnt0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ysyx_22050019_pipe_reg #(.DW(DW), .RESET_VAL(RV1), .SKID(1)) u_skid (
    .clk(clk), .rst_n(rst), .flush(flush),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cnt1)
  );

  ysyx_22050019_pipe_reg #(.DW(DW), .RESET_VAL(RV0), .SKID(0)) u_noskid (
    .clk(clk), .rst_n(rst), .flush(flush),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .count(cnt0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-run scoreboards and upstream state.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] nxt1, nxt0;
  logic          f_in1, f_out1, f_in0, f_out0;

  initial begin
    // 1. Reset
    rst = 1'b1;
    tick();
    check("rst_ir1", 32'(ir1), 32'd0);
    check("rst_ir0", 32'(ir0), 32'd0);
    tick();
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    check("rst_od1", od1, RV1);
    check("rst_ov0", 32'(ov0), 32'd0);
    check("rst_od0", od0, RV0);
    check("rst_ir1_hold", 32'(ir1), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ir1", 32'(ir1), 32'd1);
    check("rel_ir0", 32'(ir0), 32'd1);

    // 2. Streaming through the skid stage
    or1 = 1'b1;
    iv1 = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      id1 = 32'(k);
      #1;
      check("str_ir", 32'(ir1), 32'd1);
      tick();
      check("str_od", od1, 32'(k));
      check("str_ov", 32'(ov1), 32'd1);
      check("str_cnt", 32'(cnt1), 32'd1);
    end
    iv1 = 1'b0;
    tick();
    check("str_drain_ov", 32'(ov1), 32'd0);

    // 3. Back-pressure fills the skid entry
    or1 = 1'b0;
    iv1 = 1'b1;
    id1 = 32'hA;
    tick();
    check("bp_cnt1", 32'(cnt1), 32'd1);
    check("bp_ir_one", 32'(ir1), 32'd1);
    id1 = 32'hB;
    tick();
    iv1 = 1'b0;
    check("bp_cnt2", 32'(cnt1), 32'd2);
    check("bp_ir_full", 32'(ir1), 32'd0);
    check("bp_od_a", od1, 32'hA);
    tick();
    check("bp_hold_od", od1, 32'hA);
    check("bp_hold_cnt", 32'(cnt1), 32'd2);
    or1 = 1'b1;
    tick();
    check("bp_od_b", od1, 32'hB);
    check("bp_cnt_after", 32'(cnt1), 32'd1);
    check("bp_ir_after", 32'(ir1), 32'd1);
    tick();
    check("bp_empty", 32'(ov1), 32'd0);

    // 4. Flush while FULL with a beat presented
    or1 = 1'b0;
    iv1 = 1'b1;
    id1 = 32'h1;
    tick();
    id1 = 32'h2;
    tick();
    check("fl_full", 32'(cnt1), 32'd2);
    id1 = 32'hC;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    iv1 = 1'b0;
    check("fl_ov", 32'(ov1), 32'd0);
    check("fl_cnt", 32'(cnt1), 32'd0);
    check("fl_ir", 32'(ir1), 32'd1);
    check("fl_keep_main", od1, 32'h1);
    iv1 = 1'b1;
    id1 = 32'hD;
    or1 = 1'b1;
    tick();
    iv1 = 1'b0;
    check("fl_next_od", od1, 32'hD);
    check("fl_next_cnt", 32'(cnt1), 32'd1);
    tick();
    check("fl_next_empty", 32'(ov1), 32'd0);

    // 5. Single-entry variant
    or0 = 1'b0;
    iv0 = 1'b1;
    id0 = 32'h11;
    #1;
    check("ns_ir_empty", 32'(ir0), 32'd1);
    tick();
    check("ns_od", od0, 32'h11);
    check("ns_cnt", 32'(cnt0), 32'd1);
    check("ns_ir_stall", 32'(ir0), 32'd0);
    id0 = 32'h22;
    tick();
    check("ns_hold", od0, 32'h11);
    or0 = 1'b1;
    #1;
    check("ns_ir_pass", 32'(ir0), 32'd1);
    tick();
    check("ns_repl_od", od0, 32'h22);
    check("ns_repl_cnt", 32'(cnt0), 32'd1);
    id0 = 32'h33;
    tick();
    check("ns_repl2_od", od0, 32'h33);
    iv0 = 1'b0;
    tick();
    check("ns_empty", 32'(ov0), 32'd0);
    check("ns_cnt0", 32'(cnt0), 32'd0);

    // Reset while holding a beat drops it
    or1 = 1'b0;
    iv1 = 1'b1;
    id1 = 32'h77;
    tick();
    iv1 = 1'b0;
    check("mr_loaded", 32'(cnt1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_cnt", 32'(cnt1), 32'd0);
    check("mr_od", od1, RV1);

    // 6. Random valid/ready against scoreboards
    nxt1 = 32'h1000;
    nxt0 = 32'h8000;
    iv1 = 1'b0;
    iv0 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      or1 = ($urandom_range(0, 9) < 7);
      or0 = ($urandom_range(0, 9) < 7);
      // Upstream holds an offered beat until it is accepted.
      if (!iv1) begin
        iv1 = ($urandom_range(0, 9) < 7);
        if (iv1) begin id1 = nxt1; nxt1 = nxt1 + 32'd1; end
      end
      if (!iv0) begin
        iv0 = ($urandom_range(0, 9) < 7);
        if (iv0) begin id0 = nxt0; nxt0 = nxt0 + 32'd1; end
      end
      #1;
      check("rnd1_cnt", 32'(cnt1), 32'(q1.size()));
      check("rnd1_ov", 32'(ov1), 32'(q1.size() != 0));
      check("rnd1_ir", 32'(ir1), 32'(q1.size() < 2));
      if (q1.size() != 0) check("rnd1_od", od1, q1[0]);
      check("rnd0_cnt", 32'(cnt0), 32'(q0.size()));
      check("rnd0_ir", 32'(ir0), 32'((q0.size() == 0) || or0));
      if (q0.size() != 0) check("rnd0_od", od0, q0[0]);
      f_in1  = iv1 & ir1;
      f_out1 = ov1 & or1;
      f_in0  = iv0 & ir0;
      f_out0 = ov0 & or0;
      tick();
      if (f_out1 && q1.size() != 0) void'(q1.pop_front());
      if (f_in1) begin q1.push_back(id1); iv1 = 1'b0; end
      if (f_out0 && q0.size() != 0) void'(q0.pop_front());
      if (f_in0) begin q0.push_back(id0); iv0 = 1'b0; end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
